// File: rtl/pc_redirect_sequencer.sv
// PC redirect sequencer: selects the PC source and drives PC write and pipeline flushes
// for exceptions, EX mispredictions, halts and ID jumps/branches. Counts committed mispredictions.
module pc_redirect_sequencer #(
    parameter int unsigned EXC_DRAIN_CYCLES = 2,
    parameter logic [6:0]  HLT_INST         = 7'h3F,
    parameter logic [6:0]  BEQ              = 7'h04,
    parameter logic [6:0]  BNE              = 7'h05,
    parameter logic [6:0]  J                = 7'h02,
    parameter logic [6:0]  JAL              = 7'h03,
    parameter logic [6:0]  JR               = 7'h08
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  id_opcode,
    input  logic        wrong_prediction,
    input  logic        exception_flag,
    input  logic        fetch_stall,
    output logic [2:0]  pc_src,
    output logic        pc_write,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        halted,
    output logic        redirect_pending,
    output logic [15:0] mispredict_count
);

    localparam logic [2:0] SRC_SEQ  = 3'b000;
    localparam logic [2:0] SRC_EXC  = 3'b001;
    localparam logic [2:0] SRC_ID   = 3'b010;
    localparam logic [2:0] SRC_HOLD = 3'b011;
    localparam logic [2:0] SRC_CORR = 3'b100;

    localparam logic [3:0] DRAIN_INIT = 4'(EXC_DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pend_src_q, pend_src_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] count_q, count_d;

    logic        is_branch;
    logic [2:0]  run_code;
    logic [2:0]  wait_code;
    logic        commit;
    logic [2:0]  commit_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_src_q  <= SRC_SEQ;
            drain_cnt_q <= 4'd0;
            count_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            pend_src_q  <= pend_src_d;
            drain_cnt_q <= drain_cnt_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        is_branch = (id_opcode == BEQ) || (id_opcode == BNE) || (id_opcode == J)
                 || (id_opcode == JAL) || (id_opcode == JR);

        // A misprediction outranks an ID-stage hlt: that hlt is on the wrong path.
        if (exception_flag)              run_code = SRC_EXC;
        else if (wrong_prediction)       run_code = SRC_CORR;
        else if (id_opcode == HLT_INST)  run_code = SRC_HOLD;
        else if (is_branch)              run_code = SRC_ID;
        else                             run_code = SRC_SEQ;

        // While waiting, only EX/exception events can upgrade the pending redirect.
        if (exception_flag)                                 wait_code = SRC_EXC;
        else if (wrong_prediction && pend_src_q != SRC_EXC) wait_code = SRC_CORR;
        else                                                wait_code = pend_src_q;
    end

    always_comb begin
        state_d          = state_q;
        pend_src_d       = pend_src_q;
        drain_cnt_d      = drain_cnt_q;
        count_d          = count_q;
        pc_src           = SRC_SEQ;
        pc_write         = 1'b0;
        flush_if_id      = 1'b0;
        flush_id_ex      = 1'b0;
        halted           = 1'b0;
        redirect_pending = 1'b0;
        commit           = 1'b0;
        commit_code      = SRC_SEQ;

        case (state_q)
            ST_RUN: begin
                if (run_code == SRC_SEQ) begin
                    pc_write = ~fetch_stall;
                end else if (fetch_stall) begin
                    pc_src     = run_code;
                    pend_src_d = run_code;
                    state_d    = ST_WAIT;
                end else begin
                    commit      = 1'b1;
                    commit_code = run_code;
                end
            end
            ST_WAIT: begin
                pc_src           = wait_code;
                pend_src_d       = wait_code;
                redirect_pending = 1'b1;
                if (!fetch_stall) begin
                    commit      = 1'b1;
                    commit_code = wait_code;
                end
            end
            ST_DRAIN: begin
                pc_write    = ~fetch_stall;
                flush_id_ex = 1'b1;
                if (drain_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_HALTED: begin
                pc_src = SRC_HOLD;
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (commit) begin
            pc_src     = commit_code;
            pend_src_d = SRC_SEQ;
            case (commit_code)
                SRC_EXC: begin
                    pc_write    = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    drain_cnt_d = DRAIN_INIT;
                    state_d     = ST_DRAIN;
                end
                SRC_CORR: begin
                    pc_write    = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    state_d     = ST_RUN;
                end
                SRC_HOLD: begin
                    pc_write    = 1'b0;
                    flush_if_id = 1'b1;
                    state_d     = ST_HALTED;
                end
                default: begin
                    pc_write    = 1'b1;
                    flush_if_id = 1'b1;
                    state_d     = ST_RUN;
                end
            endcase
        end

        // Reset masks every output immediately, whatever state the core was in.
        if (rst) begin
            pc_src           = SRC_SEQ;
            pc_write         = 1'b0;
            flush_if_id      = 1'b0;
            flush_id_ex      = 1'b0;
            halted           = 1'b0;
            redirect_pending = 1'b0;
        end
    end

    assign mispredict_count = rst ? 16'd0 : count_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Table-driven bench for pc_redirect_sequencer with a scoreboard queue of expected outputs.
module tb_pc_redirect_sequencer;

    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_HLT = 7'h3F;
    localparam logic [6:0] OP_BEQ = 7'h04;
    localparam logic [6:0] OP_BNE = 7'h05;
    localparam logic [6:0] OP_J   = 7'h02;
    localparam logic [6:0] OP_JAL = 7'h03;
    localparam logic [6:0] OP_JR  = 7'h08;

    logic        clk;
    logic        rst;
    logic [6:0]  id_opcode;
    logic        wrong_prediction;
    logic        exception_flag;
    logic        fetch_stall;
    logic [2:0]  pc_src;
    logic        pc_write;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic        redirect_pending;
    logic [15:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    pc_redirect_sequencer #(
        .EXC_DRAIN_CYCLES(2),
        .HLT_INST(OP_HLT), .BEQ(OP_BEQ), .BNE(OP_BNE),
        .J(OP_J), .JAL(OP_JAL), .JR(OP_JR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_opcode(id_opcode),
        .wrong_prediction(wrong_prediction),
        .exception_flag(exception_flag),
        .fetch_stall(fetch_stall),
        .pc_src(pc_src),
        .pc_write(pc_write),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .halted(halted),
        .redirect_pending(redirect_pending),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        wp;
        logic        exc;
        logic        stall;
        logic [2:0]  src;
        logic        pw;
        logic        fif;
        logic        fie;
        logic        hlt;
        logic        rp;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic [6:0] op, logic wp, logic exc, logic stall,
                                logic [2:0] src, logic pw, logic fif, logic fie,
                                logic hlt, logic rp, logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.wp = wp; v.exc = exc; v.stall = stall;
        v.src = src; v.pw = pw; v.fif = fif; v.fie = fie;
        v.hlt = hlt; v.rp = rp; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] op, input logic wp,
                         input logic exc, input logic stall);
        @(negedge clk);
        rst = r; id_opcode = op; wrong_prediction = wp;
        exception_flag = exc; fetch_stall = stall;
    endtask

    // Drive one cycle's inputs, queue its expectation, then compare once outputs settle.
    task automatic step(input vec_t v, input int row);
        vec_t e;
        drive(v.rst, v.op, v.wp, v.exc, v.stall);
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk("pc_src", row, 16'(pc_src), 16'(e.src));
        chk("pc_write", row, 16'(pc_write), 16'(e.pw));
        chk("flush_if_id", row, 16'(flush_if_id), 16'(e.fif));
        chk("flush_id_ex", row, 16'(flush_id_ex), 16'(e.fie));
        chk("halted", row, 16'(halted), 16'(e.hlt));
        chk("redirect_pending", row, 16'(redirect_pending), 16'(e.rp));
        chk("mispredict_count", row, mispredict_count, e.cnt);
        $display("row %0d rst=%0b op=%h wp=%0b exc=%0b stall=%0b -> src=%0d pw=%0b fif=%0b fie=%0b h=%0b rp=%0b cnt=%0d",
                 row, v.rst, v.op, v.wp, v.exc, v.stall, pc_src, pc_write,
                 flush_if_id, flush_id_ex, halted, redirect_pending, mispredict_count);
    endtask

    initial begin
        rst = 1'b1; id_opcode = OP_NOP; wrong_prediction = 1'b0;
        exception_flag = 1'b0; fetch_stall = 1'b0;

        //              rst op      wp   exc  stl  src     pw   fif  fie  hlt  rp   cnt
        tbl.push_back(mk(1, OP_BEQ, 1'b1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_BEQ, 0, 0, 0, 3'b010, 1, 1, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_HLT, 1, 0, 0, 3'b100, 1, 1, 1, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1));
        // stalled misprediction upgraded to exception, single commit, then drain
        tbl.push_back(mk(0, OP_NOP, 1, 0, 1, 3'b100, 0, 0, 0, 0, 0, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 0, 1, 1, 3'b001, 0, 0, 0, 0, 1, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 1, 3'b001, 0, 0, 0, 0, 1, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b001, 1, 1, 1, 0, 1, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 1, 0, 0, 3'b000, 1, 0, 1, 0, 0, 16'd1));
        tbl.push_back(mk(0, OP_BEQ, 0, 1, 1, 3'b000, 0, 0, 1, 0, 0, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd1));
        // stalled branch, hlt ignored in WAIT, overwritten by misprediction
        tbl.push_back(mk(0, OP_BNE, 0, 0, 1, 3'b010, 0, 0, 0, 0, 0, 16'd1));
        tbl.push_back(mk(0, OP_HLT, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 1, 0, 1, 3'b100, 0, 0, 0, 0, 1, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b100, 1, 1, 1, 0, 1, 16'd1));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd2));
        // exception + misprediction together, then reset during DRAIN
        tbl.push_back(mk(0, OP_NOP, 1, 1, 0, 3'b001, 1, 1, 1, 0, 0, 16'd2));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_J,   0, 0, 0, 3'b010, 1, 1, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_JAL, 0, 0, 0, 3'b010, 1, 1, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_JR,  0, 0, 0, 3'b010, 1, 1, 0, 0, 0, 16'd0));
        // halt, events ignored while parked, reset releases
        tbl.push_back(mk(0, OP_HLT, 0, 0, 0, 3'b011, 0, 1, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 1, 0, 3'b011, 0, 0, 0, 1, 0, 16'd0));
        tbl.push_back(mk(0, OP_BEQ, 1, 0, 0, 3'b011, 0, 0, 0, 1, 0, 16'd0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'd0));
        // stalled halt commits after the stall
        tbl.push_back(mk(0, OP_HLT, 0, 0, 1, 3'b011, 0, 0, 0, 0, 0, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b011, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk(0, OP_NOP, 0, 0, 0, 3'b011, 0, 0, 0, 1, 0, 16'd0));
        tbl.push_back(mk(1, OP_NOP, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 16'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Saturation: 65534 unchecked commits, then three checked ones and an idle cycle.
        for (int i = 0; i < 65534; i++) begin
            drive(0, OP_NOP, 1, 0, 0);
        end
        step(mk(0, OP_NOP, 1, 0, 0, 3'b100, 1, 1, 1, 0, 0, 16'hFFFE), 100);
        step(mk(0, OP_NOP, 1, 0, 0, 3'b100, 1, 1, 1, 0, 0, 16'hFFFF), 101);
        step(mk(0, OP_NOP, 1, 0, 0, 3'b100, 1, 1, 1, 0, 0, 16'hFFFF), 102);
        step(mk(0, OP_NOP, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0, 16'hFFFF), 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_sequencer.md
# pc_redirect_sequencer

Sequences every PC redirection in the pipelined CPU: exceptions, EX-stage misprediction corrections, halts and ID-stage jumps/branches. Each cycle it selects the PC source and drives PC write-enable and pipeline flushes. It holds a redirect pending while fetch is stalled, drains the pipeline after an exception, and parks the core on `hlt_inst`. It sits between the ID/EX control logic and the PC mux/fetch stage, and keeps a saturating misprediction counter for performance debug.

## Interface
- `EXC_DRAIN_CYCLES`, default 2: cycles of ID/EX flushing after an exception redirect; legal range is 1..15.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `id_opcode` in 7: opcode of the instruction in ID. Compared against the shared opcode constants `hlt_inst`, `beq`, `bne`, `j`, `jal`, `jr`.
- `wrong_prediction` in 1: EX detected a branch misprediction this cycle.
- `exception_flag` in 1: an exception was raised this cycle.
- `fetch_stall` in 1: fetch cannot accept a new PC this cycle.
- `pc_src` out 3: PC mux select.
  - 000 = PC+4
  - 001 = exception vector
  - 010 = ID target
  - 011 = hold (halt)
  - 100 = EX correction
- `pc_write` out 1: PC register load enable.
- `flush_if_id` out 1: squash the IF/ID register.
- `flush_id_ex` out 1: squash the ID/EX register.
- `halted` out 1: core is parked.
- `redirect_pending` out 1: a redirect is waiting for fetch.
- `mispredict_count` out 16: saturating count of committed EX-correction redirects.

## Operation
- States: RUN, WAIT, DRAIN, HALTED.
- Event priority, highest first: exception, wrong_prediction, `hlt_inst` in ID, jump/branch in ID (beq/bne/j/jal/jr).
  - A misprediction beats a same-cycle `hlt_inst`, because that hlt is on the wrong path.
- RUN, no event: pc_src=000, pc_write=~fetch_stall, no flush.
- RUN, event with fetch_stall=0 (commit):
  - Exception: pc_src=001, pc_write=1, both flushes=1; next state DRAIN with drain counter = EXC_DRAIN_CYCLES-1.
  - Wrong prediction: pc_src=100, pc_write=1, both flushes=1; mispredict_count+1 (saturates at 0xFFFF); stay in RUN.
  - `hlt_inst`: pc_src=011, pc_write=0, flush_if_id=1; next state HALTED.
  - Jump/branch: pc_src=010, pc_write=1, flush_if_id=1; stay in RUN.
- RUN, event with fetch_stall=1:
  - Latch the event's code into pend_src and go to WAIT.
  - Outputs that cycle: pc_src=pend code, pc_write=0, no flush.
- WAIT:
  - pc_src=pend_src and redirect_pending=1.
  - id_opcode is ignored (ID is frozen by the stall).
  - A new exception overwrites pend_src with 001. A new wrong_prediction overwrites pend_src with 100 unless pend_src is 001.
  - Commit occurs on the first cycle with fetch_stall=0. Outputs, counter update and next state are exactly as in the RUN commit row for pend_src's code, with the effective (possibly overwritten) code used.
- DRAIN:
  - pc_src=000, pc_write=~fetch_stall, flush_id_ex=1, flush_if_id=0.
  - All events are ignored.
  - The counter decrements each cycle; when it reads 0 the next state is RUN. DRAIN therefore lasts EXC_DRAIN_CYCLES cycles after the commit cycle.
- HALTED: pc_src=011, pc_write=0, halted=1, no flush. All events are ignored; only `rst` exits.

## Timing
- All outputs are combinational from state plus current inputs. A redirect reaches pc_src in the same cycle its cause is asserted, with zero latency.
- State, pend_src, drain counter and mispredict_count are registered on the rising edge of `clk`.
- While `rst`=1, outputs are forced regardless of state:
  - pc_src=000, pc_write=0, both flushes=0, halted=0, redirect_pending=0.
  - mispredict_count reads 0.
- On the edge where `rst`=1: state=RUN, pend_src=000, drain counter=0, mispredict_count=0.
- Reset asserted mid-WAIT, DRAIN or HALTED discards the pending redirect and returns to RUN.
- A simultaneous exception and wrong_prediction commits only the exception; mispredict_count is unchanged.
- A redirect commits exactly once: no duplicate flush or duplicate count across a WAIT.

## Test plan
- Reset, then id_opcode=beq with fetch_stall=0 -> same cycle pc_src=010, pc_write=1, flush_if_id=1, flush_id_ex=0; next cycle pc_src=000.
- wrong_prediction=1 and id_opcode=hlt_inst in the same cycle -> pc_src=100, both flushes=1, mispredict_count 0->1, halted stays 0.
- fetch_stall=1 for 3 cycles while wrong_prediction pulses in cycle 0, then exception in cycle 1, then fetch_stall=0:
  - pc_src=100 in cycle 0, then 001 from cycle 1 onward.
  - pc_write=0 and no flushes while stalled.
  - Single commit with pc_src=001, mispredict_count unchanged.
  - Then EXC_DRAIN_CYCLES(=2) cycles of flush_id_ex=1 and flush_if_id=0.
- id_opcode=hlt_inst -> pc_src=011, pc_write=0; halted=1 from the next cycle. A later exception_flag is ignored; `rst` pulse -> halted=0, pc_src=000.
- 65537 committed mispredictions -> mispredict_count saturates at 0xFFFF.
- `rst` asserted during DRAIN -> outputs forced per reset values the same cycle; next cycle in RUN with no flush.
